// File: rtl/pmod_tone_sequencer_pkg.sv
// Shared definitions for the PMOD tone sequencer: FSM states, counter widths,
// default tone table and a clog2 helper that never returns zero.
package pmod_tone_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int MS_W  = 10;
    localparam int REP_W = 4;

    // Default tones: 700 / 880 / 1046 Hz half-periods at 100 MHz
    localparam logic [17:0] DEF_DIV0 = 18'd71428;
    localparam logic [17:0] DEF_DIV1 = 18'd56818;
    localparam logic [17:0] DEF_DIV2 = 18'd47801;

    localparam logic [MS_W-1:0]  DEF_ON0  = 10'd200;
    localparam logic [MS_W-1:0]  DEF_ON1  = 10'd100;
    localparam logic [MS_W-1:0]  DEF_ON2  = 10'd100;
    localparam logic [MS_W-1:0]  DEF_OFF0 = 10'd0;
    localparam logic [MS_W-1:0]  DEF_OFF1 = 10'd50;
    localparam logic [MS_W-1:0]  DEF_OFF2 = 10'd50;
    localparam logic [REP_W-1:0] DEF_REP0 = 4'd1;
    localparam logic [REP_W-1:0] DEF_REP1 = 4'd3;
    localparam logic [REP_W-1:0] DEF_REP2 = 4'd3;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/pmod_tone_sequencer_tone_divider.sv
// Half-period counter and square-wave toggle. clr restarts the wave at 0 so
// every beep begins with a full DIV-clock low phase.
module tone_divider #(
    parameter int DIV_W = 18
) (
    input  logic             CLK_I,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             wave
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;

    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (clr) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (en) begin
            if (cnt_q == div - DIV_W'(1)) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLK_I or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/pmod_tone_sequencer.sv
// Multi-channel tone sequencer for the PMOD amp: trigger synchronisers,
// priority arbitration, 1 ms prescaler and the IDLE/ON/OFF beep FSM.
module pmod_tone_sequencer
    import pmod_tone_sequencer_pkg::*;
#(
    parameter int                 CLK_HZ  = 100000000,
    parameter int                 N_EVT   = 3,
    parameter int                 DIV_W   = 18,
    parameter logic [N_EVT*DIV_W-1:0] DIV_TBL = {DEF_DIV2, DEF_DIV1, DEF_DIV0},
    parameter logic [N_EVT*MS_W-1:0]  ON_MS   = {DEF_ON2, DEF_ON1, DEF_ON0},
    parameter logic [N_EVT*MS_W-1:0]  OFF_MS  = {DEF_OFF2, DEF_OFF1, DEF_OFF0},
    parameter logic [N_EVT*REP_W-1:0] REP     = {DEF_REP2, DEF_REP1, DEF_REP0},
    parameter bit                 GAIN_HI = 1'b0
) (
    input  logic                           CLK_I,
    input  logic                           rst,
    input  logic [N_EVT-1:0]               trig,
    output logic                           pmod_speaker,
    output logic                           pmod_gain,
    output logic                           pmod_enable,
    output logic                           busy,
    output logic [clog2_min1(N_EVT)-1:0]   active_ch
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PW       = clog2_min1(TICK_DIV);
    localparam int AW       = clog2_min1(N_EVT);

    logic [N_EVT-1:0] s1_q, s2_q, s3_q, arm_q;
    logic [1:0]       vld_q;
    logic [N_EVT-1:0] rise;

    state_t           state_q, state_d;
    logic [AW-1:0]    active_ch_q, active_ch_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic [REP_W-1:0] beep_q, beep_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             clr;
    logic             tick;
    logic             wave;

    logic             win_vld;
    logic [AW-1:0]    win_ch;
    logic [DIV_W-1:0] div_sel;
    logic [MS_W-1:0]  on_sel, off_sel, last_on;
    logic [REP_W-1:0] rep_sel, rep_eff;

    // arm_q keeps a level that is already high at reset release from firing:
    // a channel only arms after a genuine low sample has passed the synchroniser.
    always_ff @(posedge CLK_I or posedge rst) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            arm_q <= '0;
            vld_q <= '0;
        end else begin
            s1_q  <= trig;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            vld_q <= {vld_q[0], 1'b1};
            arm_q <= arm_q | ({N_EVT{vld_q[1]}} & ~s2_q);
        end
    end

    assign rise = s2_q & ~s3_q & arm_q;

    always_comb begin
        win_vld = 1'b0;
        win_ch  = '0;
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (rise[i]) begin
                win_vld = 1'b1;
                win_ch  = AW'(i);
            end
        end
    end

    always_comb begin
        div_sel = '0;
        on_sel  = '0;
        off_sel = '0;
        rep_sel = '0;
        for (int i = 0; i < N_EVT; i++) begin
            if (active_ch_q == AW'(i)) begin
                div_sel = DIV_TBL[i*DIV_W +: DIV_W];
                on_sel  = ON_MS[i*MS_W +: MS_W];
                off_sel = OFF_MS[i*MS_W +: MS_W];
                rep_sel = REP[i*REP_W +: REP_W];
            end
        end
    end

    assign last_on = (on_sel == '0) ? MS_W'(1) : on_sel;
    assign rep_eff = (rep_sel == '0) ? REP_W'(1) : rep_sel;
    assign tick    = (pre_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d     = state_q;
        active_ch_d = active_ch_q;
        ms_d        = ms_q;
        beep_d      = beep_q;
        pre_d       = pre_q;
        clr         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr = 1'b1;
            end
            ST_ON: begin
                pre_d = tick ? '0 : pre_q + PW'(1);
                if (tick) begin
                    if (ms_q == last_on - MS_W'(1)) begin
                        beep_d = beep_q + REP_W'(1);
                        ms_d   = '0;
                        clr    = 1'b1;
                        if (beep_q + REP_W'(1) == rep_eff) begin
                            state_d = ST_IDLE;
                        end else if (off_sel == '0) begin
                            state_d = ST_ON;
                        end else begin
                            state_d = ST_OFF;
                        end
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                end
            end
            ST_OFF: begin
                clr   = 1'b1;
                pre_d = tick ? '0 : pre_q + PW'(1);
                if (tick) begin
                    if (ms_q == off_sel - MS_W'(1)) begin
                        ms_d    = '0;
                        state_d = ST_ON;
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                clr     = 1'b1;
            end
        endcase

        // Higher-or-equal priority edge restarts the sequence from scratch
        if (win_vld && (state_q == ST_IDLE || win_ch <= active_ch_q)) begin
            state_d     = ST_ON;
            active_ch_d = win_ch;
            ms_d        = '0;
            beep_d      = '0;
            pre_d       = '0;
            clr         = 1'b1;
        end
    end

    always_ff @(posedge CLK_I or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            active_ch_q <= '0;
            ms_q        <= '0;
            beep_q      <= '0;
            pre_q       <= '0;
        end else begin
            state_q     <= state_d;
            active_ch_q <= active_ch_d;
            ms_q        <= ms_d;
            beep_q      <= beep_d;
            pre_q       <= pre_d;
        end
    end

    tone_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .CLK_I (CLK_I),
        .rst   (rst),
        .clr   (clr),
        .en    (state_q == ST_ON),
        .div   (div_sel),
        .wave  (wave)
    );

    assign pmod_enable  = (state_q == ST_ON);
    assign busy         = (state_q != ST_IDLE);
    assign pmod_speaker = wave & pmod_enable;
    assign pmod_gain    = pmod_enable & GAIN_HI;
    assign active_ch    = active_ch_q;

endmodule

// File: tb/tb_pmod_tone_sequencer.sv
// Directed and random bench for pmod_tone_sequencer with a timeline model:
// expected outputs are derived from the elapsed time since the winning trigger.
module tb_pmod_tone_sequencer;

    logic       CLK_I = 1'b0;
    logic       rst;
    logic [2:0] trig;
    logic       pmod_speaker, pmod_gain, pmod_enable, busy;
    logic [1:0] active_ch;

    always #5 CLK_I = ~CLK_I;

    pmod_tone_sequencer #(
        .CLK_HZ  (10000),
        .N_EVT   (3),
        .DIV_W   (18),
        .DIV_TBL ({18'd2, 18'd3, 18'd4}),
        .ON_MS   ({10'd1, 10'd2, 10'd2}),
        .OFF_MS  ({10'd1, 10'd1, 10'd0}),
        .REP     ({4'd3, 4'd2, 4'd1}),
        .GAIN_HI (1'b1)
    ) dut (
        .CLK_I        (CLK_I),
        .rst          (rst),
        .trig         (trig),
        .pmod_speaker (pmod_speaker),
        .pmod_gain    (pmod_gain),
        .pmod_enable  (pmod_enable),
        .busy         (busy),
        .active_ch    (active_ch)
    );

    int div_t[3] = '{4, 3, 2};
    int on_t[3]  = '{2, 2, 1};
    int off_t[3] = '{0, 1, 1};
    int rep_t[3] = '{1, 2, 3};

    int n_assert = 0;
    int n_fail   = 0;

    // Model: start edge index and channel of the sequence that should be playing
    int         cyc = 0;
    int         start = 0;
    int         ch = 0;
    bit         ever = 1'b0;
    logic [2:0] h1 = '0, h2 = '0, h3 = '0;
    int         nsamp = 0;

    int   bcnt, tog, seqs;
    logic prev_spk, prev_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int seq_len(input int c);
        int onc, rep;
        onc = ((on_t[c] == 0) ? 1 : on_t[c]) * 10;
        rep = (rep_t[c] == 0) ? 1 : rep_t[c];
        return rep * onc + (rep - 1) * off_t[c] * 10;
    endfunction

    function automatic bit m_busy(input int n);
        return ever && (n >= start) && ((n - start) < seq_len(ch));
    endfunction

    task automatic model_reset();
        ever  = 1'b0;
        ch    = 0;
        nsamp = 0;
        h1 = '0; h2 = '0; h3 = '0;
    endtask

    task automatic check_outputs();
        int   e, onc, offc, pos;
        logic xb, xe, xs;
        e  = cyc - start;
        xb = 1'b0; xe = 1'b0; xs = 1'b0;
        if (m_busy(cyc)) begin
            onc  = ((on_t[ch] == 0) ? 1 : on_t[ch]) * 10;
            offc = off_t[ch] * 10;
            pos  = e % (onc + offc);
            xb   = 1'b1;
            xe   = (pos < onc);
            xs   = xe && (((pos / div_t[ch]) % 2) == 1);
        end
        check("busy", busy, xb);
        check("enable", pmod_enable, xe);
        check("speaker", pmod_speaker, xs);
        check("gain", pmod_gain, xe);
        check("active_ch", active_ch, ch);
        check("spk_implies_en", (!pmod_enable) ? pmod_speaker : 1'b0, 1'b0);
        check("en_implies_busy", (!busy) ? pmod_enable : 1'b0, 1'b0);
        if (busy) bcnt++;
        if (pmod_speaker !== prev_spk) tog++;
        if (busy && !prev_busy) seqs++;
        prev_spk  = pmod_speaker;
        prev_busy = busy;
    endtask

    task automatic tick(input logic [2:0] tv);
        logic [2:0] r;
        int         w;
        trig = tv;
        @(posedge CLK_I);
        cyc++;
        r = (nsamp >= 3) ? (h2 & ~h3) : 3'b000;
        w = -1;
        for (int i = 2; i >= 0; i--) if (r[i]) w = i;
        if (w >= 0 && (!m_busy(cyc - 1) || w <= ch)) begin
            start = cyc;
            ch    = w;
            ever  = 1'b1;
        end
        h3 = h2; h2 = h1; h1 = tv; nsamp++;
        #1;
        check_outputs();
    endtask

    task automatic run(input int n, input logic [2:0] tv);
        for (int i = 0; i < n; i++) tick(tv);
    endtask

    task automatic clear_stats();
        bcnt = 0; tog = 0; seqs = 0;
        prev_spk = pmod_speaker; prev_busy = busy;
    endtask

    initial begin
        rst  = 1'b1;
        trig = 3'b000;
        repeat (2) @(posedge CLK_I);
        #1;
        check("rst_speaker", pmod_speaker, 1'b0);
        check("rst_enable", pmod_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_active", active_ch, 2'd0);
        rst = 1'b0;
        model_reset();
        run(5, 3'b000);

        // Single beep on channel 0
        clear_stats();
        run(1, 3'b001);
        run(40, 3'b000);
        check("single_busy_len", bcnt, 20);
        check("single_toggles", tog, 4);

        // Three beeps with gaps on channel 2
        clear_stats();
        run(2, 3'b100);
        run(70, 3'b000);
        check("repeat_busy_len", bcnt, 50);
        check("repeat_seqs", seqs, 1);

        // Asynchronous reset mid-clock during playback, trigger held afterwards
        run(1, 3'b001);
        run(6, 3'b000);
        trig = 3'b001;
        #3;
        rst = 1'b1;
        #1;
        check("arst_speaker", pmod_speaker, 1'b0);
        check("arst_enable", pmod_enable, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_active", active_ch, 2'd0);
        check("arst_gain", pmod_gain, 1'b0);
        repeat (2) @(posedge CLK_I);
        #1;
        rst = 1'b0;
        model_reset();
        clear_stats();
        run(30, 3'b001);
        check("held_after_reset", bcnt, 0);
        run(5, 3'b000);

        // Pre-emption of channel 2 by channel 0; channel 1 edge ignored
        clear_stats();
        run(1, 3'b100);
        run(14, 3'b000);
        run(1, 3'b001);
        run(8, 3'b000);
        run(1, 3'b010);
        run(4, 3'b000);
        check("preempt_active", active_ch, 2'd0);
        run(40, 3'b000);
        check("preempt_busy_len", bcnt, 15 + 20);

        // Simultaneous edges: lowest index wins
        clear_stats();
        run(1, 3'b110);
        run(6, 3'b000);
        check("simul_active", active_ch, 2'd1);
        run(70, 3'b000);
        check("simul_busy_len", bcnt, 50);

        // Held level gives exactly one sequence
        clear_stats();
        run(200, 3'b010);
        run(5, 3'b000);
        check("held_seqs", seqs, 1);
        check("held_busy_len", bcnt, 50);

        // Random trigger activity
        for (int i = 0; i < 600; i++) begin
            logic [2:0] tv;
            tv = trig;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 11) == 0) tv[b] = ~tv[b];
            tick(tv);
        end
        run(80, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
